quad_nor_gate: RTL and testbench

//   Four independent 2-input NOR gates (74x02-style), one per bit lane, used as a

---
 rtl/quad_nor_gate.sv | 26 ++
 tb/tb_quad_nor_gate.sv | 131 +++++++++++++
 2 files changed

// File: rtl/quad_nor_gate.sv
// Four independent 2-input NOR lanes: y is combinational (zero latency), y_q is a registered copy.
// y_q is captured one cycle after sampling when en=1, and holds when en=0; rst wins over en; no backpressure.
module quad_nor_gate #(
  parameter int unsigned          WIDTH   = 4,
  parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q
);

  assign y = ~(a | b);

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= RST_VAL;
    end else if (en) begin
      y_q <= y;
    end
  end

endmodule

// File: tb/tb_quad_nor_gate.sv
// Directed bench for quad_nor_gate: combinational truth table, exhaustive sweep, and y_q reset/enable/hold.
module tb_quad_nor_gate;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] y;
  logic [3:0] y_q;
  logic       clk_on;

  int checks;
  int errors;

  quad_nor_gate #(
    .WIDTH  (4),
    .RST_VAL(4'b0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en (en),
    .a  (a),
    .b  (b),
    .y  (y),
    .y_q(y_q)
  );

  // Clock stays parked low until the combinational-only check is done.
  initial begin
    clk = 1'b0;
    wait (clk_on);
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk_on = 1'b0;
    rst    = 1'b0;
    en     = 1'b0;
    a      = 4'b0000;
    b      = 4'b0000;

    // Combinational path with no clock running
    #5;
    chk("y_noclk_00", y, 4'b1111);

    a = 4'b1010; b = 4'b1001; #1;
    chk("y_1010_1001", y, 4'b0100);
    a = 4'b0101; b = 4'b0000; #1;
    chk("y_0101_0000", y, 4'b1010);
    a = 4'b0101; b = 4'b0001; #1;
    chk("y_0101_0001", y, 4'b1010);
    a = 4'b1111; b = 4'b0000; #1;
    chk("y_1111_0000", y, 4'b0000);
    a = 4'b0000; b = 4'b1100; #1;
    chk("y_0000_1100", y, 4'b0011);

    // Exhaustive sweep; expected value built lane by lane from the truth table
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        logic [3:0] av, bv, ev;
        av = 4'(i);
        bv = 4'(j);
        for (int k = 0; k < 4; k++) ev[k] = (av[k] == 1'b0 && bv[k] == 1'b0) ? 1'b1 : 1'b0;
        a = av; b = bv; #1;
        chk($sformatf("y_sweep_a%b_b%b", av, bv), y, ev);
      end
    end

    clk_on = 1'b1;

    // Reset, capture, hold
    @(negedge clk); rst = 1'b1; en = 1'b0; a = 4'b1111; b = 4'b1111;
    tick();
    chk("yq_reset", y_q, 4'b0000);

    @(negedge clk); rst = 1'b0; en = 1'b1; a = 4'b0000; b = 4'b0000;
    tick();
    chk("yq_capture_1111", y_q, 4'b1111);

    @(negedge clk); en = 1'b0; a = 4'b1111;
    tick();
    chk("yq_hold_1111", y_q, 4'b1111);
    chk("y_during_hold", y, 4'b0000);

    @(negedge clk); en = 1'b1; a = 4'b0101; b = 4'b0000;
    tick();
    chk("yq_capture_1010", y_q, 4'b1010);

    @(negedge clk); en = 1'b1; a = 4'b1010; b = 4'b1001;
    tick();
    chk("yq_capture_0100", y_q, 4'b0100);

    @(negedge clk); en = 1'b1; a = 4'b0000; b = 4'b0000;
    tick();
    chk("yq_capture_pre_rst", y_q, 4'b1111);

    // Reset and enable together: reset must win, y keeps tracking a/b
    @(negedge clk); rst = 1'b1; en = 1'b1; a = 4'b0000; b = 4'b0000;
    tick();
    chk("yq_rst_wins", y_q, 4'b0000);
    chk("y_during_rst", y, 4'b1111);

    @(negedge clk); rst = 1'b0; en = 1'b0;
    tick();
    chk("yq_hold_after_rst", y_q, 4'b0000);

    @(negedge clk); en = 1'b1; a = 4'b0011; b = 4'b0100;
    tick();
    chk("yq_first_capture", y_q, 4'b1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
